sdram_bank_tracker: RTL and testbench

//  Passive, parametrised SDRAM command monitor on the sdram_if pin bundle (bench side, pins only, never drives).

---
 rtl/sdram_bank_tracker_if.sv | 17 +
 rtl/sdram_bank_tracker.sv | 194 +++++++++++++++++++
 tb/tb_sdram_bank_tracker.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_bank_tracker_if.sv
// SDRAM command/address pin bundle shared by the controller under test (master)
// and passive monitors such as sdram_bank_tracker (slave).
interface sdram_bank_tracker_if #(
    parameter int addr_bits = 12,
    parameter int ba_bits   = 2
);
    logic                 cke;
    logic                 csn;
    logic                 rasn;
    logic                 casn;
    logic                 wen;
    logic [addr_bits-1:0] addr;
    logic [ba_bits-1:0]   ba;

    modport master (output cke, csn, rasn, casn, wen, addr, ba);
    modport slave  (input  cke, csn, rasn, casn, wen, addr, ba);
endinterface

// File: rtl/sdram_bank_tracker.sv
// Passive SDRAM command monitor: decodes the pin bundle, tracks per-bank open/row state,
// captures the mode register and reports the highest-priority timing/protocol violation.
module sdram_bank_tracker #(
    parameter int addr_bits = 12,
    parameter int ba_bits   = 2,
    parameter int T_RCD     = 3,
    parameter int T_RP      = 3,
    parameter int T_RAS     = 6,
    parameter int T_RFC     = 9,
    parameter int T_REFI    = 780
) (
    input  logic                              clk,
    input  logic                              rst,
    sdram_bank_tracker_if.slave               i_sdram,
    output logic [2:0]                        o_cmd,
    output logic                              o_cmd_vld,
    output logic [(2**ba_bits)-1:0]           o_bank_open,
    output logic [(2**ba_bits)*addr_bits-1:0] o_open_row,
    output logic [addr_bits-1:0]              o_mode_reg,
    output logic                              o_mode_vld,
    output logic                              o_err_vld,
    output logic [3:0]                        o_err_code,
    output logic [15:0]                       o_err_cnt
);
    localparam int NB = 2**ba_bits;
    localparam int CW = $clog2(T_REFI + 1) + 1;

    localparam logic [CW-1:0] C_MAX  = '1;
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] L_RCD  = CW'(T_RCD);
    localparam logic [CW-1:0] L_RP   = CW'(T_RP);
    localparam logic [CW-1:0] L_RAS  = CW'(T_RAS);
    localparam logic [CW-1:0] L_RFC  = CW'(T_RFC);
    localparam logic [CW-1:0] L_REFI = CW'(T_REFI);

    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] CMD_ACT  = 3'd1;
    localparam logic [2:0] CMD_RD   = 3'd2;
    localparam logic [2:0] CMD_WR   = 3'd3;
    localparam logic [2:0] CMD_PRE  = 3'd4;
    localparam logic [2:0] CMD_PALL = 3'd5;
    localparam logic [2:0] CMD_REF  = 3'd6;
    localparam logic [2:0] CMD_MRS  = 3'd7;

    logic [2:0]                  r_cmd;
    logic                        r_cmd_vld;
    logic [NB-1:0]               r_bank_open;
    logic [NB*addr_bits-1:0]     r_open_row;
    logic [addr_bits-1:0]        r_mode_reg;
    logic                        r_mode_vld;
    logic                        r_err_vld;
    logic [3:0]                  r_err_code;
    logic [15:0]                 r_err_cnt;
    logic                        r_refi_pend;
    logic [CW-1:0]               r_act_cnt [NB];
    logic [CW-1:0]               r_pre_cnt [NB];
    logic [CW-1:0]               r_ref_cnt;
    logic [CW-1:0]               r_refi_cnt;

    logic [2:0]                  w_cmd;
    logic [ba_bits-1:0]          w_ba;
    logic [NB-1:0]               w_ba_hot;
    logic                        w_ras_any;
    logic [3:0]                  w_cmd_err;
    logic                        w_refi_exp;
    logic                        w_refi_due;
    logic [3:0]                  w_err_code;

    function automatic logic [CW-1:0] f_inc(input logic [CW-1:0] v);
        return (v == C_MAX) ? v : v + 1'b1;
    endfunction

    assign w_ba     = i_sdram.ba;
    assign w_ba_hot = {{(NB-1){1'b0}}, 1'b1} << w_ba;

    // Burst terminate (110) and deselect/clock-disabled cycles all look like NOP.
    always_comb begin
        w_cmd = CMD_NOP;
        if (i_sdram.cke && !i_sdram.csn) begin
            case ({i_sdram.rasn, i_sdram.casn, i_sdram.wen})
                3'b011:  w_cmd = CMD_ACT;
                3'b101:  w_cmd = CMD_RD;
                3'b100:  w_cmd = CMD_WR;
                3'b010:  w_cmd = i_sdram.addr[10] ? CMD_PALL : CMD_PRE;
                3'b001:  w_cmd = CMD_REF;
                3'b000:  w_cmd = CMD_MRS;
                default: w_cmd = CMD_NOP;
            endcase
        end
    end

    // Each command can only raise its own subset of codes; order inside a branch is the priority.
    always_comb begin
        w_ras_any = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if (r_bank_open[b] && (r_act_cnt[b] < L_RAS)) w_ras_any = 1'b1;
        end
        w_cmd_err = 4'd0;
        case (w_cmd)
            CMD_ACT: begin
                if (r_bank_open[w_ba])              w_cmd_err = 4'd1;
                else if (r_pre_cnt[w_ba] < L_RP)    w_cmd_err = 4'd5;
                else if (r_ref_cnt < L_RFC)         w_cmd_err = 4'd7;
            end
            CMD_RD, CMD_WR: begin
                if (!r_bank_open[w_ba])             w_cmd_err = 4'd2;
                else if (r_act_cnt[w_ba] < L_RCD)   w_cmd_err = 4'd3;
            end
            CMD_PRE: begin
                if (r_bank_open[w_ba] && (r_act_cnt[w_ba] < L_RAS)) w_cmd_err = 4'd4;
            end
            CMD_PALL: begin
                if (w_ras_any)                      w_cmd_err = 4'd4;
            end
            CMD_REF: begin
                if (|r_bank_open)                   w_cmd_err = 4'd6;
                else if (r_ref_cnt < L_RFC)         w_cmd_err = 4'd7;
            end
            CMD_MRS: begin
                if (|r_bank_open)                   w_cmd_err = 4'd8;
            end
            default: w_cmd_err = 4'd0;
        endcase
    end

    // A refresh expiry that collides with a command error is parked for one cycle.
    assign w_refi_exp = r_mode_vld && (w_cmd != CMD_REF) && (r_refi_cnt >= L_REFI);
    assign w_refi_due = w_refi_exp || r_refi_pend;
    assign w_err_code = (w_cmd_err != 4'd0) ? w_cmd_err : (w_refi_due ? 4'd9 : 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd       <= CMD_NOP;
            r_cmd_vld   <= 1'b0;
            r_bank_open <= '0;
            r_open_row  <= '0;
            r_mode_reg  <= '0;
            r_mode_vld  <= 1'b0;
            r_err_vld   <= 1'b0;
            r_err_code  <= 4'd0;
            r_err_cnt   <= 16'd0;
            r_refi_pend <= 1'b0;
            r_ref_cnt   <= C_MAX;
            r_refi_cnt  <= C_MAX;
            for (int b = 0; b < NB; b++) begin
                r_act_cnt[b] <= C_MAX;
                r_pre_cnt[b] <= C_MAX;
            end
        end else begin
            r_cmd     <= w_cmd;
            r_cmd_vld <= (w_cmd != CMD_NOP);

            r_ref_cnt <= (w_cmd == CMD_REF) ? C_ONE : f_inc(r_ref_cnt);
            if ((w_cmd == CMD_REF) || w_refi_exp || ((w_cmd == CMD_MRS) && !r_mode_vld))
                r_refi_cnt <= C_ONE;
            else
                r_refi_cnt <= f_inc(r_refi_cnt);

            for (int b = 0; b < NB; b++) begin
                r_act_cnt[b] <= ((w_cmd == CMD_ACT) && w_ba_hot[b]) ? C_ONE : f_inc(r_act_cnt[b]);
                r_pre_cnt[b] <= (((w_cmd == CMD_PRE) && w_ba_hot[b]) || (w_cmd == CMD_PALL))
                                ? C_ONE : f_inc(r_pre_cnt[b]);
                if ((w_cmd == CMD_ACT) && w_ba_hot[b])
                    r_open_row[b*addr_bits +: addr_bits] <= i_sdram.addr;
            end

            if (w_cmd == CMD_PALL)     r_bank_open <= '0;
            else if (w_cmd == CMD_PRE) r_bank_open <= r_bank_open & ~w_ba_hot;
            else if (w_cmd == CMD_ACT) r_bank_open <= r_bank_open | w_ba_hot;

            if (w_cmd == CMD_MRS) begin
                r_mode_reg <= i_sdram.addr;
                r_mode_vld <= 1'b1;
            end

            r_err_vld   <= (w_err_code != 4'd0);
            r_refi_pend <= (w_cmd_err != 4'd0) && w_refi_due;
            if (w_err_code != 4'd0) begin
                r_err_code <= w_err_code;
                if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign o_cmd       = r_cmd;
    assign o_cmd_vld   = r_cmd_vld;
    assign o_bank_open = r_bank_open;
    assign o_open_row  = r_open_row;
    assign o_mode_reg  = r_mode_reg;
    assign o_mode_vld  = r_mode_vld;
    assign o_err_vld   = r_err_vld;
    assign o_err_code  = r_err_code;
    assign o_err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_sdram_bank_tracker.sv
// Bench for sdram_bank_tracker: directed protocol scenarios plus random command traffic,
// compared every cycle against a timestamp-based model of the SDRAM rules.
module tb_sdram_bank_tracker;
    localparam int AB = 12;
    localparam int BB = 2;
    localparam int NB = 4;
    localparam int T_RCD  = 3;
    localparam int T_RP   = 3;
    localparam int T_RAS  = 6;
    localparam int T_RFC  = 9;
    localparam int T_REFI = 780;
    localparam int NEVER  = -100000;

    localparam int K_NOP = 0, K_ACT = 1, K_RD = 2, K_WR = 3, K_PRE = 4, K_PALL = 5;
    localparam int K_REF = 6, K_MRS = 7, K_BST = 8, K_DESEL = 9, K_CKEOFF = 10;

    logic              clk;
    logic              rst;
    logic [2:0]        o_cmd;
    logic              o_cmd_vld;
    logic [NB-1:0]     o_bank_open;
    logic [NB*AB-1:0]  o_open_row;
    logic [AB-1:0]     o_mode_reg;
    logic              o_mode_vld;
    logic              o_err_vld;
    logic [3:0]        o_err_code;
    logic [15:0]       o_err_cnt;

    sdram_bank_tracker_if #(.addr_bits(AB), .ba_bits(BB)) sd ();

    sdram_bank_tracker #(
        .addr_bits(AB), .ba_bits(BB), .T_RCD(T_RCD), .T_RP(T_RP),
        .T_RAS(T_RAS), .T_RFC(T_RFC), .T_REFI(T_REFI)
    ) dut (
        .clk(clk), .rst(rst), .i_sdram(sd.slave),
        .o_cmd(o_cmd), .o_cmd_vld(o_cmd_vld), .o_bank_open(o_bank_open),
        .o_open_row(o_open_row), .o_mode_reg(o_mode_reg), .o_mode_vld(o_mode_vld),
        .o_err_vld(o_err_vld), .o_err_code(o_err_code), .o_err_cnt(o_err_cnt)
    );

    int checks;
    int errors;
    int pulses;

    // Reference model: remembers when each event happened instead of running counters.
    int            mCyc;
    int            mLastAct [NB];
    int            mLastPre [NB];
    int            mLastRef;
    int            mRefiStart;
    bit            mOpen [NB];
    logic [AB-1:0] mRow [NB];
    logic [AB-1:0] mMode;
    bit            mModeVld;
    bit            mPend;
    logic [2:0]    eCmd;
    bit            eCmdVld;
    bit            eErrVld;
    logic [3:0]    eErrCode;
    logic [15:0]   eErrCnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void modelReset();
        mCyc = 0;
        mLastRef = NEVER;
        mRefiStart = NEVER;
        for (int b = 0; b < NB; b++) begin
            mLastAct[b] = NEVER;
            mLastPre[b] = NEVER;
            mOpen[b] = 1'b0;
            mRow[b] = '0;
        end
        mMode = '0;
        mModeVld = 1'b0;
        mPend = 1'b0;
        eCmd = 3'd0;
        eCmdVld = 1'b0;
        eErrVld = 1'b0;
        eErrCode = 4'd0;
        eErrCnt = 16'd0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [NB-1:0]    eOpen;
        logic [NB*AB-1:0] eRow;
        for (int b = 0; b < NB; b++) begin
            eOpen[b] = mOpen[b];
            eRow[b*AB +: AB] = mRow[b];
        end
        check("cmd",       64'(o_cmd),       64'(eCmd));
        check("cmd_vld",   64'(o_cmd_vld),   64'(eCmdVld));
        check("bank_open", 64'(o_bank_open), 64'(eOpen));
        check("open_row",  64'(o_open_row),  64'(eRow));
        check("mode_reg",  64'(o_mode_reg),  64'(mMode));
        check("mode_vld",  64'(o_mode_vld),  64'(mModeVld));
        check("err_vld",   64'(o_err_vld),   64'(eErrVld));
        check("err_code",  64'(o_err_code),  64'(eErrCode));
        check("err_cnt",   64'(o_err_cnt),   64'(eErrCnt));
        pulses += int'(o_err_vld);
    endtask

    // Drives one command cycle (called just after a falling edge), predicts its effect,
    // then checks the outputs shortly after the next rising edge.
    task automatic applyStimulus(input int kind, input int ba, input logic [AB-1:0] addr);
        logic [AB-1:0] a;
        int c;
        int code;
        bit anyOpen;
        bit due;
        a = addr;
        if (kind == K_PRE)  a[10] = 1'b0;
        if (kind == K_PALL) a[10] = 1'b1;
        sd.cke = 1'b1;
        sd.csn = 1'b0;
        sd.ba = 2'(ba);
        sd.addr = a;
        case (kind)
            K_ACT:    {sd.rasn, sd.casn, sd.wen} = 3'b011;
            K_RD:     {sd.rasn, sd.casn, sd.wen} = 3'b101;
            K_WR:     {sd.rasn, sd.casn, sd.wen} = 3'b100;
            K_PRE,
            K_PALL:   {sd.rasn, sd.casn, sd.wen} = 3'b010;
            K_REF:    {sd.rasn, sd.casn, sd.wen} = 3'b001;
            K_MRS:    {sd.rasn, sd.casn, sd.wen} = 3'b000;
            K_BST:    {sd.rasn, sd.casn, sd.wen} = 3'b110;
            K_DESEL:  begin sd.csn = 1'b1; {sd.rasn, sd.casn, sd.wen} = 3'($urandom); end
            K_CKEOFF: begin sd.cke = 1'b0; sd.csn = 1'($urandom);
                            {sd.rasn, sd.casn, sd.wen} = 3'($urandom); end
            default:  {sd.rasn, sd.casn, sd.wen} = 3'b111;
        endcase

        c = (kind < 8) ? kind : K_NOP;
        anyOpen = 1'b0;
        for (int b = 0; b < NB; b++) anyOpen |= mOpen[b];
        code = 0;
        case (c)
            K_ACT: begin
                if (mOpen[ba])                           code = 1;
                else if (mCyc - mLastPre[ba] < T_RP)     code = 5;
                else if (mCyc - mLastRef < T_RFC)        code = 7;
            end
            K_RD, K_WR: begin
                if (!mOpen[ba])                          code = 2;
                else if (mCyc - mLastAct[ba] < T_RCD)    code = 3;
            end
            K_PRE:  if (mOpen[ba] && (mCyc - mLastAct[ba] < T_RAS)) code = 4;
            K_PALL: for (int b = 0; b < NB; b++)
                        if (mOpen[b] && (mCyc - mLastAct[b] < T_RAS)) code = 4;
            K_REF: begin
                if (anyOpen)                             code = 6;
                else if (mCyc - mLastRef < T_RFC)        code = 7;
            end
            K_MRS:  if (anyOpen) code = 8;
            default: code = 0;
        endcase

        due = mPend;
        if (mModeVld && (c != K_REF) && (mCyc - mRefiStart >= T_REFI)) begin
            due = 1'b1;
            mRefiStart = mCyc;
        end
        if ((c == K_REF) || ((c == K_MRS) && !mModeVld)) mRefiStart = mCyc;
        if (code != 0) mPend = due;
        else begin
            mPend = 1'b0;
            if (due) code = 9;
        end

        eCmd = 3'(c);
        eCmdVld = (c != K_NOP);
        eErrVld = (code != 0);
        if (code != 0) begin
            eErrCode = 4'(code);
            if (eErrCnt != 16'hFFFF) eErrCnt = eErrCnt + 16'd1;
        end

        case (c)
            K_ACT:  begin mOpen[ba] = 1'b1; mRow[ba] = a; mLastAct[ba] = mCyc; end
            K_PRE:  begin mOpen[ba] = 1'b0; mLastPre[ba] = mCyc; end
            K_PALL: for (int b = 0; b < NB; b++) begin mOpen[b] = 1'b0; mLastPre[b] = mCyc; end
            K_REF:  mLastRef = mCyc;
            K_MRS:  begin mMode = a; mModeVld = 1'b1; end
            default: ;
        endcase
        mCyc++;

        @(posedge clk);
        #1;
        checkOutput();
        @(negedge clk);
    endtask

    initial begin
        int r;
        int k;
        checks = 0;
        errors = 0;
        pulses = 0;
        rst = 1'b0;
        sd.cke = 1'b0;
        sd.csn = 1'b1;
        {sd.rasn, sd.casn, sd.wen} = 3'b111;
        sd.addr = '0;
        sd.ba = '0;
        modelReset();
        #3 rst = 1'b1;
        #1 checkOutput();
        @(posedge clk);
        #1 checkOutput();
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] legal MRS/ACT/RD/PRE sequence");
        applyStimulus(K_MRS, 0, 12'h033);
        check("mrs_mode_reg", 64'(o_mode_reg), 64'h033);
        check("mrs_mode_vld", 64'(o_mode_vld), 64'd1);
        applyStimulus(K_ACT, 0, 12'h155);
        check("act_open", 64'(o_bank_open), 64'h1);
        check("act_row", 64'(o_open_row[AB-1:0]), 64'h155);
        repeat (2) applyStimulus(K_NOP, 0, 12'h000);
        applyStimulus(K_RD, 0, 12'h010);
        check("rd_at_trcd", 64'(o_err_vld), 64'd0);
        repeat (2) applyStimulus(K_NOP, 0, 12'h000);
        applyStimulus(K_PRE, 0, 12'h000);
        check("pre_closed", 64'(o_bank_open), 64'h0);
        check("legal_cnt", 64'(o_err_cnt), 64'd0);

        $display("[TB] tRCD, tRAS and tRP violations");
        applyStimulus(K_ACT, 1, 12'h2AA);
        applyStimulus(K_NOP, 0, 12'h000);
        applyStimulus(K_RD, 1, 12'h000);
        check("rcd_vld", 64'(o_err_vld), 64'd1);
        check("rcd_code", 64'(o_err_code), 64'd3);
        check("rcd_cnt", 64'(o_err_cnt), 64'd1);
        repeat (4) applyStimulus(K_NOP, 0, 12'h000);
        applyStimulus(K_PRE, 1, 12'h000);
        applyStimulus(K_ACT, 2, 12'h0F0);
        repeat (3) applyStimulus(K_NOP, 0, 12'h000);
        applyStimulus(K_PRE, 2, 12'h000);
        check("ras_code", 64'(o_err_code), 64'd4);
        applyStimulus(K_ACT, 2, 12'h0F1);
        check("rp_code", 64'(o_err_code), 64'd5);
        check("rp_cnt", 64'(o_err_cnt), 64'd3);
        repeat (6) applyStimulus(K_NOP, 0, 12'h000);
        applyStimulus(K_PRE, 2, 12'h000);

        $display("[TB] refresh with open bank and tRFC");
        applyStimulus(K_ACT, 3, 12'h3C3);
        repeat (7) applyStimulus(K_NOP, 0, 12'h000);
        applyStimulus(K_REF, 0, 12'h000);
        check("ref_open_code", 64'(o_err_code), 64'd6);
        repeat (9) applyStimulus(K_NOP, 0, 12'h000);
        applyStimulus(K_PALL, 0, 12'h000);
        applyStimulus(K_REF, 0, 12'h000);
        check("ref_legal", 64'(o_err_vld), 64'd0);
        repeat (4) applyStimulus(K_NOP, 0, 12'h000);
        applyStimulus(K_ACT, 0, 12'h111);
        check("rfc_code", 64'(o_err_code), 64'd7);
        repeat (6) applyStimulus(K_NOP, 0, 12'h000);
        applyStimulus(K_PRE, 0, 12'h000);

        $display("[TB] random command traffic");
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 30)      k = K_NOP;
            else if (r < 36) k = K_BST;
            else if (r < 42) k = K_DESEL;
            else if (r < 48) k = K_CKEOFF;
            else if (r < 63) k = K_ACT;
            else if (r < 70) k = K_RD;
            else if (r < 77) k = K_WR;
            else if (r < 86) k = K_PRE;
            else if (r < 89) k = K_PALL;
            else if (r < 96) k = K_REF;
            else             k = K_MRS;
            applyStimulus(k, $urandom_range(0, NB - 1), 12'($urandom));
        end

        $display("[TB] refresh interval");
        repeat (10) applyStimulus(K_NOP, 0, 12'h000);
        applyStimulus(K_PALL, 0, 12'h000);
        repeat (10) applyStimulus(K_NOP, 0, 12'h000);
        applyStimulus(K_REF, 0, 12'h000);
        pulses = 0;
        repeat (2) begin
            repeat (699) applyStimulus(K_NOP, 0, 12'h000);
            applyStimulus(K_REF, 0, 12'h000);
        end
        check("refi_quiet", 64'(pulses), 64'd0);
        pulses = 0;
        repeat (781) applyStimulus(K_NOP, 0, 12'h000);
        check("refi_single", 64'(pulses), 64'd1);

        $display("[TB] refresh expiry colliding with a command error");
        while ((mCyc - mRefiStart) < T_REFI) applyStimulus(K_NOP, 0, 12'h000);
        applyStimulus(K_RD, 0, 12'h000);
        check("defer_cmd_code", 64'(o_err_code), 64'd2);
        applyStimulus(K_NOP, 0, 12'h000);
        check("defer_refi_vld", 64'(o_err_vld), 64'd1);
        check("defer_refi_code", 64'(o_err_code), 64'd9);

        $display("[TB] reset in the middle of traffic");
        applyStimulus(K_ACT, 0, 12'h0AB);
        applyStimulus(K_ACT, 1, 12'h0CD);
        applyStimulus(K_NOP, 0, 12'h000);
        applyStimulus(K_RD, 0, 12'h000);
        #2 rst = 1'b1;
        modelReset();
        #1 checkOutput();
        @(posedge clk);
        #1 checkOutput();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(K_ACT, 0, 12'h123);
        check("post_rst_err", 64'(o_err_vld), 64'd0);
        check("post_rst_open", 64'(o_bank_open), 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
